sdram_wr_burst: RTL and testbench

SDRAM_WR_BURST -- requirements
Module: sdram_wr_burst

---
 rtl/sdram_wr_burst_pkg.sv | 32 +++
 rtl/sdram_wr_fifo.sv | 67 ++++++
 rtl/sdram_wr_burst.sv | 167 ++++++++++++++++
 tb/tb_sdram_wr_burst.sv | 551 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wr_burst_pkg.sv
// rtl/sdram_wr_burst_pkg.sv - shared frame geometry, colours, FSM states and helpers
package sdram_wr_burst_pkg;

    localparam int DATA_W      = 16;
    localparam int BURST_LEN   = 256;
    localparam int FIFO_DEPTH  = 512;
    localparam int H_DISP      = 640;
    localparam int V_DISP      = 480;
    localparam int FRAME_WORDS = H_DISP * V_DISP;
    localparam int ADDR_W      = 22;

    // RGB565 colours shared with the pixel source
    localparam logic [DATA_W-1:0] COLOR_BLACK   = 16'h0000;
    localparam logic [DATA_W-1:0] COLOR_WHITE   = 16'hFFFF;
    localparam logic [DATA_W-1:0] COLOR_RED     = 16'hF800;
    localparam logic [DATA_W-1:0] COLOR_GREEN   = 16'h07E0;
    localparam logic [DATA_W-1:0] COLOR_BLUE    = 16'h001F;
    localparam logic [DATA_W-1:0] COLOR_YELLOW  = 16'hFFE0;
    localparam logic [DATA_W-1:0] COLOR_CYAN    = 16'h07FF;
    localparam logic [DATA_W-1:0] COLOR_MAGENTA = 16'hF81F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } wr_state_t;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// rtl/sdram_wr_fifo.sv - single-clock pixel FIFO with registered read data
module sdram_wr_fifo #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 512,
    parameter int LEVEL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    // a full FIFO still takes a word when one leaves in the same cycle
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_wr_burst.sv
// rtl/sdram_wr_burst.sv - buffers pixel words and issues SDRAM write bursts per frame
module sdram_wr_burst #(
    parameter int DATA_W      = sdram_wr_burst_pkg::DATA_W,
    parameter int BURST_LEN   = sdram_wr_burst_pkg::BURST_LEN,
    parameter int FIFO_DEPTH  = sdram_wr_burst_pkg::FIFO_DEPTH,
    parameter int FRAME_WORDS = sdram_wr_burst_pkg::FRAME_WORDS,
    parameter int ADDR_W      = sdram_wr_burst_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              wr_load,
    input  logic [1:0]        wr_bank,
    input  logic              sys_we,
    input  logic [DATA_W-1:0] sys_data,
    output logic              burst_req,
    input  logic              burst_ack,
    output logic [ADDR_W-1:0] burst_addr,
    output logic [1:0]        burst_bank,
    output logic [8:0]        burst_len,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              burst_done,
    output logic              frame_done,
    output logic [9:0]        fifo_level,
    output logic              overflow,
    output logic              underflow
);

    import sdram_wr_burst_pkg::*;

    wr_state_t         state;
    wr_state_t         state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        bank_reg;
    logic [1:0]        pend_bank;
    logic              load_pending;
    logic [31:0]       remaining;
    logic [31:0]       need;
    logic [31:0]       next_addr;
    logic              frame_wrap;
    logic              load_now;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    // burst size and frame wrap computed in 32-bit so the frame end compare is exact
    always_comb begin
        remaining  = 32'(FRAME_WORDS) - 32'(addr);
        need       = min_u32(32'(BURST_LEN), remaining);
        next_addr  = 32'(addr) + 32'(burst_len);
        frame_wrap = (next_addr == 32'(FRAME_WORDS));
        load_now   = (state == IDLE) && (wr_load || load_pending);
        fifo_pop   = (state == XFER) && wr_data_req;
    end

    sdram_wr_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (10)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (load_now),
        .push      (sys_we),
        .push_data (sys_data),
        .pop       (fifo_pop),
        .rd_data   (wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: a burst starts only once enough words are buffered and no restart waits
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sdram_init_done && !wr_load && !load_pending &&
                    (32'(fifo_level) >= need)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (burst_ack) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (burst_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // burst request and descriptor, latched when a request is raised
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_req  <= 1'b0;
            burst_addr <= '0;
            burst_bank <= 2'd0;
            burst_len  <= 9'd0;
        end else begin
            burst_req <= (state_next == REQ);
            if (state == IDLE && state_next == REQ) begin
                burst_addr <= addr;
                burst_bank <= bank_reg;
                burst_len  <= 9'(need);
            end
        end
    end

    // frame address, bank selection and deferred frame restart
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            bank_reg     <= 2'd0;
            pend_bank    <= 2'd0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_now) begin
                addr         <= '0;
                bank_reg     <= wr_load ? wr_bank : pend_bank;
                load_pending <= 1'b0;
            end else if (state == XFER && burst_done) begin
                addr       <= frame_wrap ? '0 : ADDR_W'(next_addr);
                frame_done <= frame_wrap;
            end
            if (wr_load && state != IDLE) begin
                load_pending <= 1'b1;
                pend_bank    <= wr_bank;
            end
        end
    end

    // sticky error flags, cleared by a frame restart
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load_now) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (sys_we && fifo_full && !(fifo_pop && !fifo_empty)) begin
                overflow <= 1'b1;
            end
            if (fifo_pop && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// tb/tb_sdram_wr_burst.sv - self-checking bench for sdram_wr_burst
module tb_sdram_wr_burst;

    localparam int BL = 256;
    localparam int FW = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_init_done;
    logic        wr_load;
    logic [1:0]  wr_bank;
    logic        sys_we;
    logic [15:0] sys_data;
    logic        burst_req;
    logic        burst_ack;
    logic [21:0] burst_addr;
    logic [1:0]  burst_bank;
    logic [8:0]  burst_len;
    logic        wr_data_req;
    logic [15:0] wr_data;
    logic        burst_done;
    logic        frame_done;
    logic [9:0]  fifo_level;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q[$];
    logic [15:0] got_q[$];
    int          model_addr = 0;
    logic [1:0]  model_bank = 2'd0;

    sdram_wr_burst #(
        .DATA_W      (16),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (512),
        .FRAME_WORDS (FW),
        .ADDR_W      (22)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .wr_load         (wr_load),
        .wr_bank         (wr_bank),
        .sys_we          (sys_we),
        .sys_data        (sys_data),
        .burst_req       (burst_req),
        .burst_ack       (burst_ack),
        .burst_addr      (burst_addr),
        .burst_bank      (burst_bank),
        .burst_len       (burst_len),
        .wr_data_req     (wr_data_req),
        .wr_data         (wr_data),
        .burst_done      (burst_done),
        .frame_done      (frame_done),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_words(input int n, input int max_gap);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
            d = 16'($urandom);
            sys_we = 1'b1;
            sys_data = d;
            model_q.push_back(d);
            step();
            sys_we = 1'b0;
        end
    endtask

    task automatic pull_words(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
            wr_data_req = 1'b1;
            step();
            got_q.push_back(wr_data);
            wr_data_req = 1'b0;
        end
    endtask

    task automatic wait_req(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            if (burst_req === 1'b1) ok = 1'b1;
            else step();
        end
    endtask

    task automatic ack_burst();
        burst_ack = 1'b1;
        step();
        burst_ack = 1'b0;
    endtask

    function automatic int model_next_len();
        return (FW - model_addr < BL) ? FW - model_addr : BL;
    endfunction

    task automatic model_advance(input int len, output bit wrap);
        model_addr += len;
        wrap = 1'b0;
        if (model_addr == FW) begin
            model_addr = 0;
            wrap = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sdram_init_done = 1'b0;
        wr_load = 1'b0;
        wr_bank = 2'd0;
        sys_we = 1'b0;
        sys_data = '0;
        burst_ack = 1'b0;
        wr_data_req = 1'b0;
        burst_done = 1'b0;
        repeat (3) step();
        checks++;
        if ({burst_req, frame_done, overflow, underflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {burst_req, frame_done, overflow, underflow});
        end
        checks++;
        if (burst_addr !== 22'd0 || burst_bank !== 2'd0 || burst_len !== 9'd0) begin
            failures++;
            $display("FAIL reset_desc: got addr=%0d bank=%0d len=%0d expected 0/0/0", burst_addr, burst_bank, burst_len);
        end
        checks++;
        if (wr_data !== 16'd0 || fifo_level !== 10'd0) begin
            failures++;
            $display("FAIL reset_data: got wr_data=%0h level=%0d expected 0/0", wr_data, fifo_level);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_burst();
        bit ok;
        logic [15:0] last;
        logic [15:0] exp;
        sdram_init_done = 1'b1;
        push_words(BL - 1, 0);
        repeat (4) step();
        checks++;
        if (burst_req !== 1'b0 || fifo_level !== 10'(BL - 1)) begin
            failures++;
            $display("FAIL single_early: got req=%b level=%0d expected 0/%0d", burst_req, fifo_level, BL - 1);
        end
        push_words(1, 0);
        wait_req(20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_req_timeout: got req=%b expected 1", burst_req);
        end
        checks++;
        if (burst_addr !== 22'(model_addr) || burst_len !== 9'(model_next_len()) || burst_bank !== model_bank) begin
            failures++;
            $display("FAIL single_desc: got addr=%0d len=%0d bank=%0d expected %0d/%0d/%0d",
                     burst_addr, burst_len, burst_bank, model_addr, model_next_len(), model_bank);
        end
        ack_burst();
        checks++;
        if (burst_req !== 1'b0) begin
            failures++;
            $display("FAIL single_req_drop: got %b expected 0", burst_req);
        end
        got_q.delete();
        pull_words(BL, 2);
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (got_q[i] !== exp) begin
                failures++;
                $display("FAIL single_data[%0d]: got %h expected %h", i, got_q[i], exp);
            end
        end
        last = got_q[BL - 1];
        pull_words(1, 0);
        checks++;
        if (underflow !== 1'b1 || wr_data !== last) begin
            failures++;
            $display("FAIL single_underflow: got uf=%b data=%h expected 1/%h", underflow, wr_data, last);
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        begin
            bit wrap;
            model_advance(BL, wrap);
            checks++;
            if (frame_done !== wrap || fifo_level !== 10'd0 || burst_req !== 1'b0) begin
                failures++;
                $display("FAIL single_done: got fd=%b level=%0d req=%b expected %b/0/0", frame_done, fifo_level, burst_req, wrap);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit wrap;
        int len;
        int dly;
        logic [15:0] exp;
        for (int b = 0; b < 4; b++) begin
            len = model_next_len();
            push_words(len, 1);
            wait_req(50, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_req_timeout[%0d]: got req=%b expected 1", b, burst_req);
            end
            checks++;
            if (burst_addr !== 22'(model_addr) || burst_len !== 9'(len) || burst_bank !== model_bank) begin
                failures++;
                $display("FAIL b2b_desc[%0d]: got addr=%0d len=%0d bank=%0d expected %0d/%0d/%0d",
                         b, burst_addr, burst_len, burst_bank, model_addr, len, model_bank);
            end
            dly = $urandom_range(1, 3);
            repeat (dly) begin
                step();
                checks++;
                if (burst_req !== 1'b1 || burst_addr !== 22'(model_addr)) begin
                    failures++;
                    $display("FAIL b2b_hold[%0d]: got req=%b addr=%0d expected 1/%0d", b, burst_req, burst_addr, model_addr);
                end
            end
            ack_burst();
            got_q.delete();
            pull_words(len, 1);
            for (int i = 0; i < len; i++) begin
                exp = model_q.pop_front();
                checks++;
                if (got_q[i] !== exp) begin
                    failures++;
                    $display("FAIL b2b_data[%0d][%0d]: got %h expected %h", b, i, got_q[i], exp);
                end
            end
            burst_done = 1'b1;
            model_advance(len, wrap);
            step();
            burst_done = 1'b0;
            checks++;
            if (frame_done !== wrap) begin
                failures++;
                $display("FAIL b2b_frame_done[%0d]: got %b expected %b", b, frame_done, wrap);
            end
            step();
            checks++;
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_frame_pulse[%0d]: got %b expected 0", b, frame_done);
            end
        end
    endtask

    task automatic test_overflow();
        sdram_init_done = 1'b0;
        wr_load = 1'b1;
        wr_bank = 2'd0;
        step();
        wr_load = 1'b0;
        model_q.delete();
        model_addr = 0;
        model_bank = 2'd0;
        checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0 || fifo_level !== 10'd0) begin
            failures++;
            $display("FAIL ovf_load_clear: got uf=%b of=%b level=%0d expected 0/0/0", underflow, overflow, fifo_level);
        end
        push_words(512, 0);
        checks++;
        if (fifo_level !== 10'd512 || overflow !== 1'b0 || burst_req !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: got level=%0d of=%b req=%b expected 512/0/0", fifo_level, overflow, burst_req);
        end
        sys_we = 1'b1;
        sys_data = 16'($urandom);
        step();
        sys_we = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 10'd512) begin
            failures++;
            $display("FAIL ovf_drop: got of=%b level=%0d expected 1/512", overflow, fifo_level);
        end
        wr_data_req = 1'b1;
        step();
        wr_data_req = 1'b0;
        checks++;
        if (fifo_level !== 10'd512 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_idle_pull: got level=%0d uf=%b expected 512/0", fifo_level, underflow);
        end
        sys_we = 1'b1;
        wr_load = 1'b1;
        step();
        sys_we = 1'b0;
        wr_load = 1'b0;
        model_q.delete();
        checks++;
        if (fifo_level !== 10'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_load_wins: got level=%0d of=%b expected 0/0", fifo_level, overflow);
        end
        push_words(3, 0);
        checks++;
        if (fifo_level !== 10'd3) begin
            failures++;
            $display("FAIL ovf_noinit_push: got level=%0d expected 3", fifo_level);
        end
        wr_load = 1'b1;
        step();
        wr_load = 1'b0;
        model_q.delete();
        sdram_init_done = 1'b1;
    endtask

    task automatic test_full_push_pop();
        bit ok;
        logic [15:0] exp;
        push_words(512, 0);
        wait_req(10, ok);
        checks++;
        if (!ok || fifo_level !== 10'd512 || burst_len !== 9'(BL) || burst_addr !== 22'd0) begin
            failures++;
            $display("FAIL fpp_req: got req=%b level=%0d len=%0d addr=%0d expected 1/512/%0d/0",
                     burst_req, fifo_level, burst_len, burst_addr, BL);
        end
        ack_burst();
        got_q.delete();
        sys_we = 1'b1;
        sys_data = 16'($urandom);
        model_q.push_back(sys_data);
        wr_data_req = 1'b1;
        step();
        got_q.push_back(wr_data);
        sys_we = 1'b0;
        wr_data_req = 1'b0;
        checks++;
        if (fifo_level !== 10'd512 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fpp_level: got level=%0d of=%b expected 512/0", fifo_level, overflow);
        end
        pull_words(BL - 1, 0);
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (got_q[i] !== exp) begin
                failures++;
                $display("FAIL fpp_data[%0d]: got %h expected %h", i, got_q[i], exp);
            end
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        wr_load = 1'b1;
        wr_bank = 2'd0;
        step();
        wr_load = 1'b0;
        model_q.delete();
        model_addr = 0;
        step();
        checks++;
        if (fifo_level !== 10'd0 || burst_req !== 1'b0) begin
            failures++;
            $display("FAIL fpp_restart: got level=%0d req=%b expected 0/0", fifo_level, burst_req);
        end
    endtask

    task automatic test_load_mid_xfer();
        bit ok;
        logic [15:0] exp;
        push_words(BL, 0);
        wait_req(10, ok);
        checks++;
        if (!ok || burst_bank !== 2'd0 || burst_addr !== 22'd0) begin
            failures++;
            $display("FAIL lmx_req: got req=%b bank=%0d addr=%0d expected 1/0/0", burst_req, burst_bank, burst_addr);
        end
        ack_burst();
        got_q.delete();
        pull_words(100, 0);
        wr_load = 1'b1;
        wr_bank = 2'd2;
        step();
        wr_load = 1'b0;
        push_words(40, 0);
        repeat (40) void'(model_q.pop_back());
        pull_words(BL - 100, 1);
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (got_q[i] !== exp) begin
                failures++;
                $display("FAIL lmx_data[%0d]: got %h expected %h", i, got_q[i], exp);
            end
        end
        checks++;
        if (burst_bank !== 2'd0 || burst_addr !== 22'd0) begin
            failures++;
            $display("FAIL lmx_stable: got bank=%0d addr=%0d expected 0/0", burst_bank, burst_addr);
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        step();
        model_q.delete();
        model_addr = 0;
        model_bank = 2'd2;
        checks++;
        if (fifo_level !== 10'd0 || burst_req !== 1'b0) begin
            failures++;
            $display("FAIL lmx_flush: got level=%0d req=%b expected 0/0", fifo_level, burst_req);
        end
        push_words(BL - 1, 0);
        repeat (5) step();
        checks++;
        if (burst_req !== 1'b0) begin
            failures++;
            $display("FAIL lmx_early: got req=%b expected 0", burst_req);
        end
        push_words(1, 0);
        wait_req(10, ok);
        checks++;
        if (!ok || burst_addr !== 22'd0 || burst_bank !== model_bank || burst_len !== 9'(BL)) begin
            failures++;
            $display("FAIL lmx_next: got req=%b addr=%0d bank=%0d len=%0d expected 1/0/%0d/%0d",
                     burst_req, burst_addr, burst_bank, burst_len, model_bank, BL);
        end
        ack_burst();
        got_q.delete();
        pull_words(BL, 0);
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (got_q[i] !== exp) begin
                failures++;
                $display("FAIL lmx_data2[%0d]: got %h expected %h", i, got_q[i], exp);
            end
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        model_addr = BL;
    endtask

    task automatic test_rst_mid_xfer();
        bit ok;
        logic [15:0] exp;
        wr_load = 1'b1;
        wr_bank = 2'd0;
        step();
        wr_load = 1'b0;
        model_q.delete();
        model_addr = 0;
        model_bank = 2'd0;
        push_words(BL, 0);
        wait_req(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rmx_req_timeout: got req=%b expected 1", burst_req);
        end
        ack_burst();
        pull_words(100, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({burst_req, frame_done, overflow, underflow} !== 4'b0000 ||
            burst_addr !== 22'd0 || burst_bank !== 2'd0 || burst_len !== 9'd0 ||
            wr_data !== 16'd0 || fifo_level !== 10'd0) begin
            failures++;
            $display("FAIL rmx_reset: got req=%b fd=%b of=%b uf=%b addr=%0d bank=%0d len=%0d data=%h level=%0d expected all 0",
                     burst_req, frame_done, overflow, underflow, burst_addr, burst_bank, burst_len, wr_data, fifo_level);
        end
        wr_data_req = 1'b1;
        step();
        wr_data_req = 1'b0;
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        checks++;
        if (underflow !== 1'b0 || fifo_level !== 10'd0 || burst_req !== 1'b0) begin
            failures++;
            $display("FAIL rmx_ignore: got uf=%b level=%0d req=%b expected 0/0/0", underflow, fifo_level, burst_req);
        end
        model_q.delete();
        push_words(BL - 1, 0);
        repeat (5) step();
        checks++;
        if (burst_req !== 1'b0) begin
            failures++;
            $display("FAIL rmx_early: got req=%b expected 0", burst_req);
        end
        push_words(1, 0);
        wait_req(10, ok);
        checks++;
        if (!ok || burst_addr !== 22'd0 || burst_bank !== 2'd0 || burst_len !== 9'(BL)) begin
            failures++;
            $display("FAIL rmx_next: got req=%b addr=%0d bank=%0d len=%0d expected 1/0/0/%0d",
                     burst_req, burst_addr, burst_bank, burst_len, BL);
        end
        ack_burst();
        got_q.delete();
        pull_words(BL, 1);
        for (int i = 0; i < BL; i++) begin
            exp = model_q.pop_front();
            checks++;
            if (got_q[i] !== exp) begin
                failures++;
                $display("FAIL rmx_data[%0d]: got %h expected %h", i, got_q[i], exp);
            end
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_load_mid_xfer();
        test_rst_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
